// File: rtl/reset_sequencer_ctrl_if.sv
// Reset sequencer control bus: lock/ack inputs towards the controller and the
// sequenced domain resets plus status back out to the shell.
interface reset_sequencer_ctrl_if #(
  parameter int unsigned NUM_DOMAINS = 4
);

  logic                   pll_locked;
  logic                   sw_reset;
  logic [NUM_DOMAINS-1:0] domain_ready;
  logic [NUM_DOMAINS-1:0] domain_reset;
  logic                   all_ready;
  logic [2:0]             seq_state;
  logic                   timeout_err;

  // Shell / environment side: drives lock, requests and acks
  modport master (
    output pll_locked, sw_reset, domain_ready,
    input  domain_reset, all_ready, seq_state, timeout_err
  );

  // Controller side
  modport slave (
    input  pll_locked, sw_reset, domain_ready,
    output domain_reset, all_ready, seq_state, timeout_err
  );

endinterface

// File: rtl/reset_sequencer_ctrl.sv
// Always-on reset sequencer: qualifies PLL lock, holds every domain in reset
// for a debounce period, then releases domains one at a time in index order,
// waiting for each domain's synchronized ready acknowledgement.
// Optional feature macro: RESET_SEQ_TIMEOUT_EN (bounded ack wait with sticky
// timeout_err and automatic retry from HOLD).
module reset_sequencer_ctrl #(
  parameter int unsigned NUM_DOMAINS    = 4,
  parameter int unsigned HOLD_CYCLES    = 256,
  parameter int unsigned STEP_CYCLES    = 16,
  parameter int unsigned LOCK_SYNC      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                    clock,
  input logic                    areset,
  reset_sequencer_ctrl_if.slave  bus
);

  localparam int unsigned MAX_HS     = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam int unsigned IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RELEASE   = 3'd2,
    WAIT_ACK  = 3'd3,
    STEP      = 3'd4,
    RUN       = 3'd5
  } state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       idx, idx_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [NUM_DOMAINS-1:0] domain_reset_q, domain_reset_next;
  logic                   all_ready_q, all_ready_next;

  logic [LOCK_SYNC-1:0]                  lock_sync;
  logic [LOCK_SYNC-1:0][NUM_DOMAINS-1:0] ready_sync;
  logic                                  lock_s;
  logic [NUM_DOMAINS-1:0]                ready_s;
  logic                                  abortable;

  assign lock_s    = lock_sync[LOCK_SYNC-1];
  assign ready_s   = ready_sync[LOCK_SYNC-1];
  assign abortable = (state == HOLD) || (state == RELEASE) || (state == WAIT_ACK) ||
                     (state == STEP) || (state == RUN);

  // Multi-flop synchronizers for the asynchronous lock and ack inputs
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      lock_sync  <= '0;
      ready_sync <= '0;
    end else begin
      lock_sync  <= {lock_sync[LOCK_SYNC-2:0], bus.pll_locked};
      ready_sync <= {ready_sync[LOCK_SYNC-2:0], bus.domain_ready};
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  logic timeout_q, timeout_next, timeout_hit;
`endif

  // State, index, counter and registered outputs
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state          <= WAIT_LOCK;
      idx            <= '0;
      cnt            <= '0;
      domain_reset_q <= '1;
      all_ready_q    <= 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      timeout_q      <= 1'b0;
`endif
    end else begin
      state          <= state_next;
      idx            <= idx_next;
      cnt            <= cnt_next;
      domain_reset_q <= domain_reset_next;
      all_ready_q    <= all_ready_next;
`ifdef RESET_SEQ_TIMEOUT_EN
      timeout_q      <= timeout_next;
`endif
    end
  end

  // Next-state: normal sequencing, then aborts (lock loss over sw_reset) override
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
`ifdef RESET_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_next = RELEASE;
          idx_next   = '0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_next = WAIT_ACK;
        cnt_next   = '0;
      end
      WAIT_ACK: begin
        if (ready_s[idx]) begin
          state_next = STEP;
          cnt_next   = '0;
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next  = HOLD;
          idx_next    = '0;
          cnt_next    = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
`endif
      end
      STEP: begin
        if (cnt == CNT_W'(STEP_CYCLES - 1)) begin
          cnt_next = '0;
          if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
            state_next = RUN;
          end else begin
            state_next = RELEASE;
            idx_next   = idx + IDX_W'(1);
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = WAIT_LOCK;
        idx_next   = '0;
        cnt_next   = '0;
      end
    endcase

    if (abortable && !lock_s) begin
      state_next = WAIT_LOCK;
      idx_next   = '0;
      cnt_next   = '0;
`ifdef RESET_SEQ_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
    end else if (abortable && bus.sw_reset) begin
      state_next = HOLD;
      idx_next   = '0;
      cnt_next   = '0;
`ifdef RESET_SEQ_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
    end
  end

  // Output decode from the next state: domains below idx are released, idx
  // itself once RELEASE has been left
  always_comb begin
    domain_reset_next = '1;
    all_ready_next    = 1'b0;
    case (state_next)
      RUN: begin
        domain_reset_next = '0;
        all_ready_next    = 1'b1;
      end
      RELEASE, WAIT_ACK, STEP: begin
        for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
          if ((i < int'(idx_next)) || ((i == int'(idx_next)) && (state_next != RELEASE))) begin
            domain_reset_next[i] = 1'b0;
          end
        end
      end
      default: begin
        domain_reset_next = '1;
      end
    endcase
`ifdef RESET_SEQ_TIMEOUT_EN
    timeout_next = timeout_q | timeout_hit;
`endif
  end

  assign bus.domain_reset = domain_reset_q;
  assign bus.all_ready    = all_ready_q;
  assign bus.seq_state    = state;
`ifdef RESET_SEQ_TIMEOUT_EN
  assign bus.timeout_err  = timeout_q;
`else
  assign bus.timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer_ctrl.sv
// Directed bench for reset_sequencer_ctrl (3 domains, hold 8, step 4, sync 2,
// timeout 32). Timeout scenario is selected by RESET_SEQ_TIMEOUT_EN.
module tb_reset_sequencer_ctrl;

  localparam int unsigned ND = 3;

  logic clock = 1'b0;
  logic areset;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  reset_sequencer_ctrl_if #(.NUM_DOMAINS(ND)) bus();

  reset_sequencer_ctrl #(
    .NUM_DOMAINS   (ND),
    .HOLD_CYCLES   (8),
    .STEP_CYCLES   (4),
    .LOCK_SYNC     (2),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clock (clock),
    .areset(areset),
    .bus   (bus.slave)
  );

  // One active edge, then settle to the sampling point on the falling edge
  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Bounded wait for a given state/reset pattern
  task automatic wait_state(input logic [2:0] st, input logic [ND-1:0] dr, input int limit,
                            output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit && !ok; k++) begin
      cyc();
      if (bus.seq_state === st && bus.domain_reset === dr) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    bus.pll_locked   = 1'b0;
    bus.sw_reset     = 1'b0;
    bus.domain_ready = '0;
    @(negedge clock);
    @(negedge clock);
    checks++; if (bus.domain_reset !== 3'b111) begin errors++; $display("FAIL rst_domain_reset got %b expected 111", bus.domain_reset); end
    checks++; if (bus.seq_state !== 3'd0) begin errors++; $display("FAIL rst_seq_state got %0d expected 0", bus.seq_state); end
    checks++; if (bus.all_ready !== 1'b0) begin errors++; $display("FAIL rst_all_ready got %b expected 0", bus.all_ready); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %b expected 0", bus.timeout_err); end
    areset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      bus.sw_reset = (c == 50);
      cyc();
      checks++;
      if (bus.domain_reset !== 3'b111 || bus.all_ready !== 1'b0 || bus.seq_state !== 3'd0) begin
        errors++;
        $display("FAIL idle_unlocked cycle %0d got dr=%b rdy=%b st=%0d expected dr=111 rdy=0 st=0",
                 c, bus.domain_reset, bus.all_ready, bus.seq_state);
      end
    end
    bus.sw_reset = 1'b0;
  endtask

  task automatic test_sequence();
    int f0 = -1, f1 = -1, f2 = -1, fr = -1;
    bus.pll_locked   = 1'b1;
    bus.domain_ready = 3'b111;
    for (int e = 1; e <= 60; e++) begin
      cyc();
      checks++;
      if (!(bus.domain_reset === 3'b111 || bus.domain_reset === 3'b110 ||
            bus.domain_reset === 3'b100 || bus.domain_reset === 3'b000)) begin
        errors++; $display("FAIL release_order edge %0d got %b expected thermometer pattern", e, bus.domain_reset);
      end
      if (e == 11) begin checks++; if (bus.seq_state !== 3'd2) begin errors++; $display("FAIL seq_release_state got %0d expected 2", bus.seq_state); end end
      if (e == 12) begin checks++; if (bus.seq_state !== 3'd3) begin errors++; $display("FAIL seq_waitack_state got %0d expected 3", bus.seq_state); end end
      if (e == 13) begin checks++; if (bus.seq_state !== 3'd4) begin errors++; $display("FAIL seq_step_state got %0d expected 4", bus.seq_state); end end
      if (f0 < 0 && bus.domain_reset[0] === 1'b0) f0 = e;
      if (f1 < 0 && bus.domain_reset[1] === 1'b0) f1 = e;
      if (f2 < 0 && bus.domain_reset[2] === 1'b0) f2 = e;
      if (fr < 0 && bus.all_ready === 1'b1) begin
        fr = e;
        break;
      end
    end
    checks++; if (f0 !== 12) begin errors++; $display("FAIL dom0_release_edge got %0d expected 12", f0); end
    checks++; if (f1 !== 18) begin errors++; $display("FAIL dom1_release_edge got %0d expected 18", f1); end
    checks++; if (f2 !== 24) begin errors++; $display("FAIL dom2_release_edge got %0d expected 24", f2); end
    checks++; if (fr !== 29) begin errors++; $display("FAIL all_ready_edge got %0d expected 29", fr); end
    checks++; if (bus.seq_state !== 3'd5 || bus.domain_reset !== 3'b000) begin
      errors++; $display("FAIL run_outputs got st=%0d dr=%b expected st=5 dr=000", bus.seq_state, bus.domain_reset);
    end
  endtask

  task automatic test_lock_loss();
    bit ok;
    bus.pll_locked = 1'b0;
    cyc();
    bus.pll_locked = 1'b1;
    checks++; if (bus.seq_state !== 3'd5) begin errors++; $display("FAIL lock_drop_a1 got %0d expected 5", bus.seq_state); end
    cyc();
    checks++; if (bus.all_ready !== 1'b1) begin errors++; $display("FAIL lock_drop_a2 got %b expected 1", bus.all_ready); end
    cyc();
    checks++; if (bus.seq_state !== 3'd0 || bus.domain_reset !== 3'b111 || bus.all_ready !== 1'b0) begin
      errors++; $display("FAIL lock_loss_abort got st=%0d dr=%b rdy=%b expected st=0 dr=111 rdy=0",
                         bus.seq_state, bus.domain_reset, bus.all_ready);
    end
    cyc();
    checks++; if (bus.seq_state !== 3'd1) begin errors++; $display("FAIL relock_hold got %0d expected 1", bus.seq_state); end
    repeat (7) cyc();
    checks++; if (bus.seq_state !== 3'd1) begin errors++; $display("FAIL relock_hold_end got %0d expected 1", bus.seq_state); end
    cyc();
    checks++; if (bus.seq_state !== 3'd2 || bus.domain_reset !== 3'b111) begin
      errors++; $display("FAIL relock_release got st=%0d dr=%b expected st=2 dr=111", bus.seq_state, bus.domain_reset);
    end
    cyc();
    checks++; if (bus.seq_state !== 3'd3 || bus.domain_reset !== 3'b110) begin
      errors++; $display("FAIL relock_dom0 got st=%0d dr=%b expected st=3 dr=110", bus.seq_state, bus.domain_reset);
    end
    wait_state(3'd5, 3'b000, 60, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL relock_run_timeout got %b expected 1", ok); end
  endtask

  task automatic test_abort_priority();
    bit ok;
    bus.domain_ready = 3'b001;
    bus.sw_reset = 1'b1;
    cyc();
    bus.sw_reset = 1'b0;
    checks++; if (bus.seq_state !== 3'd1 || bus.domain_reset !== 3'b111 || bus.all_ready !== 1'b0) begin
      errors++; $display("FAIL sw_from_run got st=%0d dr=%b rdy=%b expected st=1 dr=111 rdy=0",
                         bus.seq_state, bus.domain_reset, bus.all_ready);
    end
    wait_state(3'd3, 3'b100, 60, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reach_waitack1 got %b expected 1", ok); end
    bus.pll_locked = 1'b0;
    cyc();
    cyc();
    checks++; if (bus.seq_state !== 3'd3) begin errors++; $display("FAIL waitack_before_lock_s got %0d expected 3", bus.seq_state); end
    bus.sw_reset = 1'b1;
    cyc();
    bus.sw_reset   = 1'b0;
    bus.pll_locked = 1'b1;
    checks++; if (bus.seq_state !== 3'd0 || bus.domain_reset !== 3'b111) begin
      errors++; $display("FAIL lock_beats_sw got st=%0d dr=%b expected st=0 dr=111", bus.seq_state, bus.domain_reset);
    end
    wait_state(3'd3, 3'b100, 60, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reach_waitack1_again got %b expected 1", ok); end
    bus.sw_reset = 1'b1;
    cyc();
    bus.sw_reset = 1'b0;
    checks++; if (bus.seq_state !== 3'd1 || bus.domain_reset !== 3'b111) begin
      errors++; $display("FAIL sw_only_abort got st=%0d dr=%b expected st=1 dr=111", bus.seq_state, bus.domain_reset);
    end
    repeat (7) cyc();
    checks++; if (bus.seq_state !== 3'd1) begin errors++; $display("FAIL sw_hold_full got %0d expected 1", bus.seq_state); end
    cyc();
    checks++; if (bus.seq_state !== 3'd2) begin errors++; $display("FAIL sw_hold_exit got %0d expected 2", bus.seq_state); end
  endtask

`ifdef RESET_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    wait_state(3'd3, 3'b100, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_reach_waitack1 got %b expected 1", ok); end
    for (int k = 1; k <= 32; k++) begin
      cyc();
      if (k < 32) begin
        checks++;
        if (bus.seq_state !== 3'd3 || bus.timeout_err !== 1'b0) begin
          errors++; $display("FAIL to_waiting cycle %0d got st=%0d err=%b expected st=3 err=0", k, bus.seq_state, bus.timeout_err);
        end
      end else begin
        checks++;
        if (bus.seq_state !== 3'd1 || bus.domain_reset !== 3'b111 || bus.timeout_err !== 1'b1) begin
          errors++; $display("FAIL to_expire got st=%0d dr=%b err=%b expected st=1 dr=111 err=1",
                             bus.seq_state, bus.domain_reset, bus.timeout_err);
        end
      end
    end
    bus.domain_ready = 3'b111;
    wait_state(3'd5, 3'b000, 80, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL to_retry_run got %b expected 1", ok); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b expected 1", bus.timeout_err); end
  endtask
`else
  task automatic test_no_timeout();
    bit ok;
    wait_state(3'd3, 3'b100, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nt_reach_waitack1 got %b expected 1", ok); end
    for (int k = 0; k < 60; k++) begin
      cyc();
      checks++;
      if (bus.seq_state !== 3'd3 || bus.timeout_err !== 1'b0 || bus.domain_reset !== 3'b100) begin
        errors++; $display("FAIL nt_wait_forever cycle %0d got st=%0d dr=%b err=%b expected st=3 dr=100 err=0",
                           k, bus.seq_state, bus.domain_reset, bus.timeout_err);
      end
    end
  endtask
`endif

  task automatic test_async_reset();
    bit ok;
    bus.domain_ready = 3'b111;
    bus.sw_reset = 1'b1;
    cyc();
    bus.sw_reset = 1'b0;
    wait_state(3'd4, 3'b000, 80, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reach_step2 got %b expected 1", ok); end
    #2 areset = 1'b1;
    #1;
    checks++; if (bus.domain_reset !== 3'b111 || bus.seq_state !== 3'd0 ||
                  bus.all_ready !== 1'b0 || bus.timeout_err !== 1'b0) begin
      errors++; $display("FAIL async_reset got dr=%b st=%0d rdy=%b err=%b expected dr=111 st=0 rdy=0 err=0",
                         bus.domain_reset, bus.seq_state, bus.all_ready, bus.timeout_err);
    end
    @(negedge clock);
    areset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_lock_loss();
    test_abort_priority();
`ifdef RESET_SEQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
